// File: rtl/fft_mem_seq.sv
// In-place FFT memory sequencer for a 16-bank SRAM array: per stage, a read pass,
// a wait for the datapath, and a write pass over the same conflict-free addresses.
module fft_mem_seq #(
  parameter int unsigned ROWS      = 4096,
  parameter int unsigned NUM_STAGE = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic        PE_ACK,
  output logic        WE,
  output logic [11:0] ADDR0,
  output logic [11:0] ADDR1,
  output logic [11:0] ADDR2,
  output logic [11:0] ADDR3,
  output logic [11:0] ADDR4,
  output logic [11:0] ADDR5,
  output logic [11:0] ADDR6,
  output logic [11:0] ADDR7,
  output logic [11:0] ADDR8,
  output logic [11:0] ADDR9,
  output logic [11:0] ADDR10,
  output logic [11:0] ADDR11,
  output logic [11:0] ADDR12,
  output logic [11:0] ADDR13,
  output logic [11:0] ADDR14,
  output logic [11:0] ADDR15,
  output logic        RD_VLD,
  output logic        WR_ACT,
  output logic [1:0]  STAGE,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FIN} state_t;

  localparam logic [11:0] ROW_LAST = 12'(ROWS - 1);
  localparam logic [1:0]  STG_LAST = 2'(NUM_STAGE - 1);

  state_t      state, nxt_state;
  logic [11:0] row, nxt_row;
  logic [1:0]  stage, nxt_stage;

  logic        we_d, busy_d, done_d;
  logic [11:0] addr_d [16];
  logic [11:0] addr_q [16];

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      row   <= '0;
      stage <= '0;
    end else begin
      state <= nxt_state;
      row   <= nxt_row;
      stage <= nxt_stage;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_stage = stage;
    case (state)
      IDLE: begin
        if (START) begin
          nxt_state = RD;
          nxt_row   = '0;
          nxt_stage = '0;
        end
      end
      RD: begin
        if (row == ROW_LAST) begin
          nxt_state = WAIT;
          nxt_row   = '0;
        end else begin
          nxt_row = row + 12'd1;
        end
      end
      WAIT: begin
        nxt_row = '0;
        if (PE_ACK) nxt_state = WR;
      end
      WR: begin
        if (row == ROW_LAST) begin
          nxt_row = '0;
          if (stage < STG_LAST) begin
            nxt_stage = stage + 2'd1;
            nxt_state = RD;
          end else begin
            nxt_state = FIN;
          end
        end else begin
          nxt_row = row + 12'd1;
        end
      end
      FIN: begin
        nxt_state = IDLE;
        nxt_row   = '0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_row   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with the access cycle
  always_comb begin
    we_d   = (nxt_state == WR);
    busy_d = (nxt_state == RD) || (nxt_state == WAIT) || (nxt_state == WR);
    done_d = (nxt_state == FIN);
    for (int unsigned k = 0; k < 16; k++) begin
      if ((nxt_state == RD) || (nxt_state == WR))
        addr_d[k] = nxt_row ^ (12'(k) << {nxt_stage, 2'b00});
      else
        addr_d[k] = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      WE     <= 1'b0;
      RD_VLD <= 1'b0;
      STAGE  <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) addr_q[k] <= '0;
    end else begin
      WE     <= we_d;
      RD_VLD <= (state == RD);
      STAGE  <= nxt_stage;
      BUSY   <= busy_d;
      DONE   <= done_d;
      for (int unsigned k = 0; k < 16; k++) addr_q[k] <= addr_d[k];
    end
  end

  assign WR_ACT = WE;

  assign ADDR0  = addr_q[0];
  assign ADDR1  = addr_q[1];
  assign ADDR2  = addr_q[2];
  assign ADDR3  = addr_q[3];
  assign ADDR4  = addr_q[4];
  assign ADDR5  = addr_q[5];
  assign ADDR6  = addr_q[6];
  assign ADDR7  = addr_q[7];
  assign ADDR8  = addr_q[8];
  assign ADDR9  = addr_q[9];
  assign ADDR10 = addr_q[10];
  assign ADDR11 = addr_q[11];
  assign ADDR12 = addr_q[12];
  assign ADDR13 = addr_q[13];
  assign ADDR14 = addr_q[14];
  assign ADDR15 = addr_q[15];

endmodule

// File: tb/tb_fft_mem_seq.sv
// Self-checking bench for fft_mem_seq: per-cycle scoreboard on a small instance,
// plus a full-size run on a large instance for the address and issue-count boundary.
module tb_fft_mem_seq;

  localparam int ROWS = 4;
  localparam int NS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0, start = 1'b0, pe_ack = 1'b0;
  logic        we, rd_vld, wr_act, busy, done;
  logic [1:0]  stage;
  logic [11:0] addr [16];

  logic        rstn_b = 1'b0, start_b = 1'b0, ack_b = 1'b0;
  logic        we_b, rd_vld_b, wr_act_b, busy_b, done_b;
  logic [1:0]  stage_b;
  logic [11:0] addr_b [16];

  fft_mem_seq #(.ROWS(ROWS), .NUM_STAGE(NS)) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .PE_ACK(pe_ack), .WE(we),
    .ADDR0(addr[0]), .ADDR1(addr[1]), .ADDR2(addr[2]), .ADDR3(addr[3]),
    .ADDR4(addr[4]), .ADDR5(addr[5]), .ADDR6(addr[6]), .ADDR7(addr[7]),
    .ADDR8(addr[8]), .ADDR9(addr[9]), .ADDR10(addr[10]), .ADDR11(addr[11]),
    .ADDR12(addr[12]), .ADDR13(addr[13]), .ADDR14(addr[14]), .ADDR15(addr[15]),
    .RD_VLD(rd_vld), .WR_ACT(wr_act), .STAGE(stage), .BUSY(busy), .DONE(done)
  );

  fft_mem_seq #(.ROWS(4096), .NUM_STAGE(3)) dut_big (
    .CLK(clk), .RSTN(rstn_b), .START(start_b), .PE_ACK(ack_b), .WE(we_b),
    .ADDR0(addr_b[0]), .ADDR1(addr_b[1]), .ADDR2(addr_b[2]), .ADDR3(addr_b[3]),
    .ADDR4(addr_b[4]), .ADDR5(addr_b[5]), .ADDR6(addr_b[6]), .ADDR7(addr_b[7]),
    .ADDR8(addr_b[8]), .ADDR9(addr_b[9]), .ADDR10(addr_b[10]), .ADDR11(addr_b[11]),
    .ADDR12(addr_b[12]), .ADDR13(addr_b[13]), .ADDR14(addr_b[14]), .ADDR15(addr_b[15]),
    .RD_VLD(rd_vld_b), .WR_ACT(wr_act_b), .STAGE(stage_b), .BUSY(busy_b), .DONE(done_b)
  );

  typedef struct packed {
    logic              rstn, start, ack;
    logic              chk, chk_stg;
    logic              we, rdv, busy, done;
    logic [1:0]        stg;
    logic [15:0][11:0] a;
  } step_t;

  step_t plan[$];
  step_t sbq[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_addr(input int k, input int r, input int s);
    int t;
    t = (k << (4 * s)) ^ r;
    return t[11:0];
  endfunction

  task automatic push_step(input logic rs, st, ak, input logic ck, cs,
                           input logic w, rv, bz, dn, input int sg, input int row, input bit act);
    step_t p;
    p.rstn = rs; p.start = st; p.ack = ak;
    p.chk = ck; p.chk_stg = cs;
    p.we = w; p.rdv = rv; p.busy = bz; p.done = dn;
    p.stg = sg[1:0];
    for (int k = 0; k < 16; k++) p.a[k] = act ? exp_addr(k, row, sg) : 12'h000;
    plan.push_back(p);
  endtask

  // One run: START in an idle cycle, then per stage RD, d WAIT cycles (ack on the d-th), WR, then FIN.
  task automatic plan_run(input int d, input bit glitch, input int abort_row);
    push_step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < NS; s++) begin
      for (int r = 0; r < ROWS; r++)
        push_step(1, glitch && r == 2, glitch && r == 1, 1, 1, 0, r > 0, 1, 0, s, r, 1);
      for (int w = 1; w <= d; w++)
        push_step(1, 0, w == d, 1, 1, 0, w == 1, 1, 0, s, 0, 0);
      for (int r = 0; r < ROWS; r++) begin
        if (s == 0 && r == abort_row) begin
          push_step(0, 0, 0, 1, 1, 1, 0, 1, 0, s, r, 1);
          push_step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
          return;
        end
        push_step(1, glitch && r == 1, glitch && r == 2, 1, 1, 1, 0, 1, 0, s, r, 1);
      end
    end
    push_step(1, glitch, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    push_step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_plan();
    step_t p;
    while (plan.size() > 0) begin
      p = plan.pop_front();
      @(posedge clk); #1;
      rstn = p.rstn; start = p.start; pe_ack = p.ack;
      sbq.push_back(p);
    end
    @(posedge clk); #1;
    start = 1'b0; pe_ack = 1'b0;
    @(negedge clk);
  endtask

  step_t e;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cyc++;
      if (e.chk) begin
        check($sformatf("we@%0d", cyc), we, e.we);
        check($sformatf("wr_act@%0d", cyc), wr_act, e.we);
        check($sformatf("rd_vld@%0d", cyc), rd_vld, e.rdv);
        check($sformatf("busy@%0d", cyc), busy, e.busy);
        check($sformatf("done@%0d", cyc), done, e.done);
        if (e.chk_stg) check($sformatf("stage@%0d", cyc), stage, e.stg);
        for (int k = 0; k < 16; k++)
          check($sformatf("addr%0d@%0d", k, cyc), addr[k], e.a[k]);
      end
    end
  end

  task automatic big_run();
    int rd_cnt [3];
    int wr_cnt [3];
    int n_done;
    bit finished;
    for (int s = 0; s < 3; s++) begin rd_cnt[s] = 0; wr_cnt[s] = 0; end
    n_done = 0;
    finished = 0;
    @(posedge clk); #1;
    rstn_b = 1'b1; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; ack_b = 1'b1;
    for (int c = 0; c < 30000 && !finished; c++) begin
      @(negedge clk);
      if (rd_vld_b) rd_cnt[stage_b]++;
      if (we_b) begin
        if (stage_b == 2'd2 && wr_cnt[2] == 4095) begin
          check("big_addr15_row4095", addr_b[15], 12'h0FF);
          check("big_addr0_row4095", addr_b[0], 12'hFFF);
        end
        wr_cnt[stage_b]++;
      end
      if (done_b) begin
        n_done++;
        check("big_busy_at_done", busy_b, 1'b0);
        finished = 1;
      end
    end
    check("big_done_seen", finished, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done_b) n_done++;
    end
    check("big_done_count", n_done, 1);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("big_rd_cnt_s%0d", s), rd_cnt[s], 4096);
      check($sformatf("big_wr_cnt_s%0d", s), wr_cnt[s], 4096);
    end
  endtask

  initial begin
    // Reset, including START asserted alongside reset
    push_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_step(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    push_step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    push_step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    plan_run(3, 0, -1);
    plan_run(51, 0, -1);
    plan_run(3, 1, -1);
    plan_run(3, 0, 1);
    for (int i = 0; i < 3; i++) push_step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    plan_run(2, 0, -1);
    drive_plan();
    big_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fft_mem_seq.md
FFT_MEM_SEQ -- requirements
Module: fft_mem_seq

Interface
REQ-001 Parameter ROWS, default 4096: rows accessed per pass per bank; legal range 2..4096.
REQ-002 Parameter NUM_STAGE, default 3: stages per run; legal range 1..3.
REQ-003 CLK  input  1: single clock; all state updates on its rising edge.
REQ-004 RSTN  input  1: reset, synchronous and active-low.
REQ-005 START  input  1: one-cycle run request.
REQ-006 PE_ACK  input  1: datapath signals that write data for the current stage is ready.
REQ-007 WE  output  1: write enable to all 16 banks of the 16-bank SRAM array (1 = write, 0 = read).
REQ-008 ADDR0..ADDR15  output  12 each: per-bank row address.
REQ-009 RD_VLD  output  1: Q0..Q15 of the array hold read data this cycle.
REQ-010 WR_ACT  output  1: a write is issued this cycle (equals WE).
REQ-011 STAGE  output  2: index of the current stage.
REQ-012 BUSY  output  1: a run is in progress.
REQ-013 DONE  output  1: one-cycle pulse when a run completes.

Function
REQ-014 States SHALL be IDLE, RD, WAIT, WR and FIN, held in a registered FSM.
REQ-015 In IDLE with START=1, the block SHALL load row=0 and STAGE=0, then enter RD on the next cycle.
REQ-016 In RD, the block SHALL hold WE=0, issue one read row per cycle with row running 0..ROWS-1, and enter WAIT after row ROWS-1.
REQ-017 In WR, the block SHALL hold WE=1, issue one write row per cycle with row running 0..ROWS-1, then act as follows after row ROWS-1:
- if STAGE<NUM_STAGE-1: increment STAGE, reset row to 0, enter RD;
- otherwise: enter FIN.
REQ-018 In WAIT, WE SHALL be 0 and the row counter SHALL be 0; the block SHALL enter WR in the cycle after PE_ACK is sampled at 1, and SHALL wait indefinitely otherwise.
REQ-019 FIN SHALL last exactly one cycle, assert DONE=1 and return to IDLE.
REQ-020 Address rule: ADDRk = (row XOR (k << (4*STAGE))) mod 4096, computed at 12 bits with bits above 11 discarded; read and write passes of the same stage SHALL use identical addresses for the same row, so the update is in place and bank-conflict-free.
REQ-021 ADDRk and WE SHALL be registered outputs, valid in the cycle the access is issued.
REQ-022 RD_VLD SHALL equal 1 exactly one cycle after each RD-state read issue, matching the 1-cycle registered array read.
REQ-023 RD_VLD SHALL therefore be 1 in the first WAIT cycle, for the final row.
REQ-024 ADDRk SHALL be 0 in IDLE, WAIT and FIN.
REQ-025 BUSY SHALL be 1 in RD, WAIT and WR, and 0 in IDLE and FIN.
REQ-026 START received while BUSY=1 or in FIN SHALL be ignored.
REQ-027 PE_ACK outside WAIT SHALL be ignored.
REQ-028 The row counter SHALL never exceed ROWS-1.
REQ-029 With ROWS=4096, the row counter SHALL wrap to 0 without overflow into STAGE.
REQ-030 WE SHALL never be 1 during RD, and there SHALL be no cycle in which a read and a write are both issued.

Reset
REQ-031 With RSTN=0 at a clock edge, the block SHALL enter IDLE and clear the row counter.
REQ-032 Reset SHALL drive every output to 0: WE, ADDR0..15, RD_VLD, WR_ACT, STAGE, BUSY and DONE.
REQ-033 Reset mid-run (in RD, WAIT or WR) SHALL abort the run, raise no DONE, and assert no WE from the following cycle onward.
REQ-034 If START=1 and RSTN=0 in the same cycle, reset SHALL win.

Verification (bench uses ROWS=4, NUM_STAGE=2 unless stated)
REQ-035 Basic run: START pulse at cycle 0, then PE_ACK pulsed on the 3rd WAIT cycle of each stage -> the bench SHALL check all of the following:
- RD spans cycles 1-4;
- RD_VLD is 1 in cycles 2-5;
- WR spans 4 cycles with WE=1;
- STAGE goes 0 then 1;
- DONE pulses once;
- BUSY falls in the DONE cycle.
REQ-036 Address pattern: in stage 1, row 2 -> ADDR0=0x002, ADDR1=0x012, ADDR15=0x0F2.
REQ-037 Address pattern: in stage 0, row 3 -> ADDR5=0x006.
REQ-038 Handshake: PE_ACK held low for 50 cycles -> the block stays in WAIT with WE=0 and BUSY=1, and WR starts the cycle after PE_ACK=1.
REQ-039 Ignored inputs: START pulsed during WR and PE_ACK pulsed during RD -> no change in state sequence or cycle count.
REQ-040 Reset mid-operation: RSTN=0 during WR row 1 -> next cycle all outputs are 0, and a subsequent START runs a full correct sequence.
REQ-041 Boundary: with ROWS=4096 and NUM_STAGE=3, stage 2 row 4095 gives ADDR15 = 4095 XOR 0xF00 = 0x0FF, then DONE follows after the WR pass, with 2*4096 issues per stage.
